// File: rtl/loom_axil_reg_bridge.sv
// AXI4-Lite slave to single-outstanding req/ack register bus, with per-request
// acknowledge timeout so a hung peripheral yields DECERR instead of a stall.
module loom_axil_reg_bridge #(
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned ACK_TIMEOUT   = 16,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  reg_req_o,
  output logic                  reg_we_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [31:0]           reg_wdata_o,
  output logic [3:0]            reg_be_o,
  input  logic                  reg_ack_i,
  input  logic [31:0]           reg_rdata_i,
  input  logic                  reg_err_i,
  output logic                  timeout_o
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_t;
  typedef enum logic {GRANT_WRITE, GRANT_READ} grant_t;

  state_t state_q, state_d;
  grant_t last_grant_q;

  logic                  aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic [CNT_W-1:0]      cnt_q;

  logic aw_hs, w_hs, ar_hs;
  logic wr_ready, rd_ready;
  logic grant_wr, grant_rd, req_done, req_timeout, req_end;

  assign s_axil_awready = !aw_full_q;
  assign s_axil_wready  = !w_full_q;
  assign s_axil_arready = !ar_full_q;

  assign aw_hs = s_axil_awvalid && !aw_full_q;
  assign w_hs  = s_axil_wvalid  && !w_full_q;
  assign ar_hs = s_axil_arvalid && !ar_full_q;

  assign wr_ready = aw_full_q && w_full_q;
  assign rd_ready = ar_full_q;

  assign reg_req_o     = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign s_axil_bvalid = (state_q == WR_RESP);
  assign s_axil_rvalid = (state_q == RD_RESP);
  assign req_end       = req_done || req_timeout;

  always_comb begin
    state_d     = state_q;
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    req_done    = 1'b0;
    req_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        // Round-robin only matters when both are ready; the loser of the last grant wins.
        if (wr_ready && (!rd_ready || last_grant_q == GRANT_READ)) begin
          grant_wr = 1'b1;
          state_d  = WR_REQ;
        end else if (rd_ready) begin
          grant_rd = 1'b1;
          state_d  = RD_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        if (reg_ack_i) begin
          req_done = 1'b1;
        end else if (ACK_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          req_timeout = 1'b1;
        end
        if (req_done || req_timeout) begin
          state_d = (state_q == WR_REQ) ? WR_RESP : RD_RESP;
        end
      end
      WR_RESP: if (s_axil_bready) state_d = IDLE;
      RD_RESP: if (s_axil_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (req_end && state_q == WR_REQ) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_addr_q <= s_axil_awaddr & ADDR_MASK;
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          w_data_q <= s_axil_wdata;
          w_strb_q <= s_axil_wstrb;
        end
      end
      if (req_end && state_q == RD_REQ) begin
        ar_full_q <= 1'b0;
      end else if (ar_hs) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= s_axil_araddr & ADDR_MASK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_WRITE;
      reg_we_o     <= 1'b0;
      reg_addr_o   <= '0;
      reg_wdata_o  <= '0;
      reg_be_o     <= '0;
      cnt_q        <= '0;
      s_axil_bresp <= '0;
      s_axil_rresp <= '0;
      s_axil_rdata <= '0;
      timeout_o    <= 1'b0;
    end else begin
      timeout_o <= req_timeout;
      if (grant_wr) begin
        last_grant_q <= GRANT_WRITE;
        reg_we_o     <= 1'b1;
        reg_addr_o   <= aw_addr_q;
        reg_wdata_o  <= w_data_q;
        reg_be_o     <= w_strb_q;
      end else if (grant_rd) begin
        last_grant_q <= GRANT_READ;
        reg_we_o     <= 1'b0;
        reg_addr_o   <= ar_addr_q;
      end
      if (reg_req_o && !req_end) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (req_end && state_q == WR_REQ) begin
        s_axil_bresp <= req_timeout ? 2'b11 : (reg_err_i ? 2'b10 : 2'b00);
      end
      if (req_end && state_q == RD_REQ) begin
        s_axil_rresp <= req_timeout ? 2'b11 : (reg_err_i ? 2'b10 : 2'b00);
        s_axil_rdata <= req_timeout ? TIMEOUT_RDATA : reg_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_loom_axil_reg_bridge.sv
// Directed bench for loom_axil_reg_bridge: scoreboard of expected register requests
// and AXI responses, with a programmable-latency peripheral model.
module tb_loom_axil_reg_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] s_axil_awaddr, s_axil_araddr;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready;
  logic        s_axil_arvalid, s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid, s_axil_rready;
  logic        reg_req_o, reg_we_o;
  logic [19:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_be_o;
  logic        reg_ack_i;
  logic [31:0] reg_rdata_i;
  logic        reg_err_i;
  logic        timeout_o;

  always #5 clk = ~clk;

  loom_axil_reg_bridge #(
    .ADDR_WIDTH(20),
    .ACK_TIMEOUT(16),
    .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o), .reg_ack_i(reg_ack_i),
    .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i), .timeout_o(timeout_o)
  );

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    bit          rd;
    logic [1:0]  resp;
    logic [31:0] data;
    int          len;
    int          tos;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int ack_delay = 0;   // ack in req cycle ack_delay+1; negative = never ack
  int req_cyc = 0;
  int last_req_len = 0;
  int to_cnt = 0;
  int to_base = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peripheral model and request-side scoreboard, sampled 1 time unit after each edge.
  initial begin
    reg_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (timeout_o) to_cnt++;
      if (reg_req_o) begin
        req_cyc++;
        if (req_cyc == 1) begin
          check("req_expected", exp_req_q.size() != 0, 1);
          if (exp_req_q.size() != 0) begin
            req_t e;
            e = exp_req_q.pop_front();
            check("req_we", reg_we_o, e.we);
            check("req_addr", reg_addr_o, e.addr);
            if (e.we) begin
              check("req_wdata", reg_wdata_o, e.wdata);
              check("req_be", reg_be_o, e.be);
            end
          end
        end
        reg_ack_i = (ack_delay >= 0) && (req_cyc == ack_delay + 1);
      end else begin
        if (req_cyc != 0) last_req_len = req_cyc;
        req_cyc   = 0;
        reg_ack_i = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic exp_wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] r, input int len, input int tos);
    req_t q;
    rsp_t p;
    q.we = 1'b1; q.addr = a; q.wdata = d; q.be = s;
    p.rd = 1'b0; p.resp = r; p.data = '0; p.len = len; p.tos = tos;
    exp_req_q.push_back(q);
    exp_rsp_q.push_back(p);
  endtask

  task automatic exp_rd(input logic [19:0] a, input logic [1:0] r, input logic [31:0] d,
                        input int len, input int tos, input bit with_rsp);
    req_t q;
    rsp_t p;
    q.we = 1'b0; q.addr = a; q.wdata = '0; q.be = '0;
    p.rd = 1'b1; p.resp = r; p.data = d; p.len = len; p.tos = tos;
    exp_req_q.push_back(q);
    if (with_rsp) exp_rsp_q.push_back(p);
  endtask

  // Called at a negedge; presents the selected channels together and returns at the
  // negedge following the last handshake.
  task automatic send(input bit do_aw, input bit do_w, input bit do_ar, input logic [19:0] awa,
                      input logic [31:0] wd, input logic [3:0] ws, input logic [19:0] ara);
    bit aw_hs, w_hs, ar_hs;
    s_axil_awaddr = awa; s_axil_wdata = wd; s_axil_wstrb = ws; s_axil_araddr = ara;
    s_axil_awvalid = do_aw; s_axil_wvalid = do_w; s_axil_arvalid = do_ar;
    for (int i = 0; i < 64 && (s_axil_awvalid || s_axil_wvalid || s_axil_arvalid); i++) begin
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid  && s_axil_wready;
      ar_hs = s_axil_arvalid && s_axil_arready;
      @(negedge clk);
      if (aw_hs) s_axil_awvalid = 1'b0;
      if (w_hs)  s_axil_wvalid  = 1'b0;
      if (ar_hs) s_axil_arvalid = 1'b0;
    end
    check("send_accepted", {s_axil_awvalid, s_axil_wvalid, s_axil_arvalid}, 3'b000);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
  endtask

  task automatic collect(input int hold);
    bit   got = 1'b0;
    rsp_t e;
    for (int i = 0; i < 100; i++) begin
      if (s_axil_bvalid || s_axil_rvalid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rsp_arrived", got, 1);
    check("rsp_expected", exp_rsp_q.size() != 0, 1);
    if (got && exp_rsp_q.size() != 0) begin
      e = exp_rsp_q.pop_front();
      check("rsp_kind", {s_axil_bvalid, s_axil_rvalid}, e.rd ? 2'b01 : 2'b10);
      if (e.rd) begin
        check("rresp", s_axil_rresp, e.resp);
        check("rdata", s_axil_rdata, e.data);
      end else begin
        check("bresp", s_axil_bresp, e.resp);
      end
      check("req_len", last_req_len, e.len);
      check("timeout_pulses", to_cnt - to_base, e.tos);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("valid_held", e.rd ? s_axil_rvalid : s_axil_bvalid, 1);
      end
      if (e.rd) s_axil_rready = 1'b1;
      else      s_axil_bready = 1'b1;
      @(negedge clk);
      s_axil_rready = 1'b0;
      s_axil_bready = 1'b0;
      check("valid_drop", s_axil_bvalid | s_axil_rvalid, 0);
    end
    to_base = to_cnt;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0; reg_rdata_i = '0; reg_err_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    check("rst_valids", {s_axil_bvalid, s_axil_rvalid, reg_req_o, reg_we_o, timeout_o}, 5'b0);
    check("rst_resp", {s_axil_bresp, s_axil_rresp, s_axil_rdata}, '0);
    check("rst_regbus", {reg_addr_o, reg_wdata_o, reg_be_o}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous write+read straight after reset: read first.
    ack_delay = 0; reg_rdata_i = 32'h1111_2222;
    exp_rd(20'h00040, 2'b00, 32'h1111_2222, 1, 0, 1'b1);
    exp_wr(20'h00080, 32'hA5A5_5A5A, 4'hC, 2'b00, 1, 0);
    send(1, 1, 1, 20'h00080, 32'hA5A5_5A5A, 4'hC, 20'h00040);
    collect(0);
    collect(0);
    // Lone read makes READ the last grant, so the next conflict goes to the write.
    exp_rd(20'h00044, 2'b00, 32'h1111_2222, 1, 0, 1'b1);
    send(0, 0, 1, '0, '0, '0, 20'h00044);
    collect(0);
    exp_wr(20'h000C0, 32'h0F0F_0F0F, 4'h5, 2'b00, 1, 0);
    exp_rd(20'h000C4, 2'b00, 32'h1111_2222, 1, 0, 1'b1);
    send(1, 1, 1, 20'h000C0, 32'h0F0F_0F0F, 4'h5, 20'h000C4);
    collect(0);
    collect(0);

    // W ahead of AW, ack 2 cycles after req, bready held off.
    ack_delay = 2;
    exp_wr(20'h00100, 32'hCAFE_F00D, 4'hF, 2'b00, 3, 0);
    send(0, 1, 0, '0, 32'hCAFE_F00D, 4'hF, '0);
    repeat (2) @(negedge clk);
    check("no_req_w_only", reg_req_o, 0);
    send(1, 0, 0, 20'h00100, '0, '0, '0);
    collect(3);

    // One-cycle ack read, with request latency and low address bits discarded.
    ack_delay = 0; reg_rdata_i = 32'h1234_5678;
    exp_rd(20'h00204, 2'b00, 32'h1234_5678, 1, 0, 1'b1);
    send(0, 0, 1, '0, '0, '0, 20'h00207);
    check("lat_e0_req", reg_req_o, 0);
    @(negedge clk);
    check("lat_e1_req", reg_req_o, 1);
    collect(1);

    // No ack: timeout after 16 req cycles.
    ack_delay = -1;
    exp_rd(20'h00300, 2'b11, 32'hDEAD_BEEF, 16, 1, 1'b1);
    send(0, 0, 1, '0, '0, '0, 20'h00300);
    collect(2);

    // Ack in the 16th req cycle wins over the timeout.
    ack_delay = 15; reg_rdata_i = 32'h0BAD_F00D;
    exp_rd(20'h00304, 2'b00, 32'h0BAD_F00D, 16, 0, 1'b1);
    send(0, 0, 1, '0, '0, '0, 20'h00304);
    collect(0);

    // Peripheral error on a write.
    ack_delay = 1; reg_err_i = 1'b1;
    exp_wr(20'h00400, 32'h0000_0001, 4'h3, 2'b10, 2, 0);
    send(1, 1, 0, 20'h00400, 32'h0000_0001, 4'h3, '0);
    collect(0);
    reg_err_i = 1'b0;

    // Zero strobes still issued; low address bits dropped.
    ack_delay = 0;
    exp_wr(20'h00308, 32'h0000_55AA, 4'h0, 2'b00, 1, 0);
    send(1, 1, 0, 20'h0030B, 32'h0000_55AA, 4'h0, '0);
    collect(0);

    // Reset while a request is outstanding.
    ack_delay = -1;
    exp_rd(20'h00500, 2'b00, '0, 0, 0, 1'b0);
    send(0, 0, 1, '0, '0, '0, 20'h00500);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (reg_req_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("req_before_reset", seen, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", reg_req_o, 0);
    check("mid_rst_valids", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
    check("mid_rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    ack_delay = 0; reg_rdata_i = 32'h600D_CAFE;
    exp_rd(20'h00504, 2'b00, 32'h600D_CAFE, 1, 0, 1'b1);
    send(0, 0, 1, '0, '0, '0, 20'h00504);
    collect(0);

    repeat (3) @(negedge clk);
    check("all_reqs_issued", exp_req_q.size(), 0);
    check("all_rsps_seen", exp_rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
